// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Holds default geometry, the init/run state encoding and an index type.
package reg_file_pkg;

    localparam int RF_REG_COUNT = 32;
    localparam int RF_WORD_SIZE = 32;
    localparam int RF_NUM_RD    = 2;
    localparam int RF_NUM_WR    = 1;
    localparam int RF_ZERO_REG  = 1;
    localparam int RF_BYPASS    = 1;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_e;

    // Register index for the default geometry.
    typedef logic [$clog2(RF_REG_COUNT)-1:0] rf_idx_t;

endpackage

// File: rtl/reg_file_init_ctrl.sv
// Post-reset clear sequencer: walks every register index once, then idles.
// Ports: clk_i, rst_ni, sweep_we_o/sweep_addr_o (clear write), init_busy_o.
module reg_file_init_ctrl
    import reg_file_pkg::*;
#(
    parameter  int REG_COUNT = RF_REG_COUNT,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          sweep_we_o,
    output logic [AW-1:0] sweep_addr_o,
    output logic          init_busy_o
);

    localparam logic [AW-1:0] LAST = AW'(REG_COUNT - 1);

    rf_state_e     state;
    logic [AW-1:0] clr_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= RF_INIT;
            clr_ptr     <= '0;
            init_busy_o <= 1'b1;
        end else begin
            unique case (state)
                RF_INIT: begin
                    if (clr_ptr == LAST) begin
                        state       <= RF_RUN;
                        init_busy_o <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                RF_RUN: begin
                    state <= RF_RUN;
                end
            endcase
        end
    end

    // Busy is high exactly while in INIT, so it doubles as the sweep strobe.
    assign sweep_we_o   = init_busy_o;
    assign sweep_addr_o = clr_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional x0 and write bypass.
// Ports: clk_i, rst_ni, rd_addr_i/rd_data_o, we_i/wr_addr_i/wr_data_i, init_busy_o.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int REG_COUNT = RF_REG_COUNT,
    parameter  int WORD_SIZE = RF_WORD_SIZE,
    parameter  int NUM_RD    = RF_NUM_RD,
    parameter  int NUM_WR    = RF_NUM_WR,
    parameter  int ZERO_REG  = RF_ZERO_REG,
    parameter  int BYPASS    = RF_BYPASS,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_RD-1:0][AW-1:0]          rd_addr_i,
    output logic [NUM_RD-1:0][WORD_SIZE-1:0]   rd_data_o,
    input  logic [NUM_WR-1:0]                  we_i,
    input  logic [NUM_WR-1:0][AW-1:0]          wr_addr_i,
    input  logic [NUM_WR-1:0][WORD_SIZE-1:0]   wr_data_i,
    output logic                               init_busy_o
);

    localparam logic [AW:0] ADDR_LIM = (AW+1)'(REG_COUNT);

    logic                 sweep_we;
    logic [AW-1:0]        sweep_addr;
    logic [NUM_WR-1:0]    wr_ok;
    logic [WORD_SIZE-1:0] mem [REG_COUNT];

    // An address is live if it exists and is not the hardwired zero.
    function automatic logic addr_live(input logic [AW-1:0] a);
        logic zero_hit;
        zero_hit = (ZERO_REG != 0) && (a == '0);
        return ({1'b0, a} < ADDR_LIM) && !zero_hit;
    endfunction

    reg_file_init_ctrl #(
        .REG_COUNT(REG_COUNT)
    ) u_init_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sweep_we_o  (sweep_we),
        .sweep_addr_o(sweep_addr),
        .init_busy_o (init_busy_o)
    );

    always_comb begin
        wr_ok = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_ok[p] = we_i[p] && !init_busy_o
                     && addr_live(wr_addr_i[p]);
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk_i) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p]) begin
                    mem[wr_addr_i[p]] <= wr_data_i[p];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (!init_busy_o && addr_live(rd_addr_i[r])) begin
                rd_data_o[r] = mem[rd_addr_i[r]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (wr_ok[p] && wr_addr_i[p] == rd_addr_i[r]) begin
                            rd_data_o[r] = wr_data_i[p];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: two instances sharing stimulus,
// 32 regs with bypass and 24 regs without bypass.
module tb_reg_file_mp;

    localparam int AW = 5;

    logic                   clk;
    logic                   rst_ni;
    logic [1:0][AW-1:0]     rd_addr;
    logic [1:0]             we;
    logic [1:0][AW-1:0]     wr_addr;
    logic [1:0][31:0]       wr_data;
    logic [1:0][31:0]       rd_a;
    logic [1:0][31:0]       rd_b;
    logic                   busy_a;
    logic                   busy_b;

    int total = 0;
    int bad   = 0;

    reg_file_mp #(
        .REG_COUNT(32), .WORD_SIZE(32), .NUM_RD(2),
        .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_a),
        .we_i       (we),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .init_busy_o(busy_a)
    );

    reg_file_mp #(
        .REG_COUNT(24), .WORD_SIZE(32), .NUM_RD(2),
        .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)
    ) u_dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_b),
        .we_i       (we),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .init_busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        we      = '0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    // Runs up to 40 cycles and records the first cycle busy is low.
    task automatic count_sweep(input int pulse_cyc,
                               output int done_a,
                               output int done_b);
        done_a = 0;
        done_b = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == pulse_cyc) begin
                we         = 2'b01;
                wr_addr[0] = 5'd2;
                wr_data[0] = 32'hBAD0_0BAD;
            end else begin
                idle_wr();
            end
            step();
            if (!busy_a && done_a == 0) done_a = c;
            if (!busy_b && done_b == 0) done_b = c;
        end
        idle_wr();
    endtask

    int da, db;

    initial begin
        rst_ni  = 1'b0;
        rd_addr = '0;
        idle_wr();
        rd_addr[0] = 5'd9;
        rd_addr[1] = 5'd17;

        // 1: reset state, sweep length, writes dropped while busy
        step();
        step();
        check("rst_busy_a", {31'd0, busy_a}, 32'd1);
        check("rst_busy_b", {31'd0, busy_b}, 32'd1);
        check("rst_rd_a0", rd_a[0], 32'd0);
        check("rst_rd_b1", rd_b[1], 32'd0);
        rst_ni = 1'b1;
        count_sweep(5, da, db);
        check("sweep_len_a", 32'(da), 32'd32);
        check("sweep_len_b", 32'(db), 32'd24);
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = AW'(a);
            rd_addr[1] = AW'(31 - a);
            #1;
            check($sformatf("clr_a_%0d", a), rd_a[0], 32'd0);
            check($sformatf("clr_b_%0d", a), rd_b[1], 32'd0);
        end

        // 2: two ports hit x5, port 1 wins
        rd_addr[0] = 5'd5;
        rd_addr[1] = 5'd0;
        we         = 2'b11;
        wr_addr[0] = 5'd5;
        wr_addr[1] = 5'd5;
        wr_data[0] = 32'hAAAA_0001;
        wr_data[1] = 32'h5555_0002;
        #1;
        check("x5_byp_a", rd_a[0], 32'h5555_0002);
        check("x5_nobyp_b", rd_b[0], 32'd0);
        step();
        idle_wr();
        #1;
        check("x5_a", rd_a[0], 32'h5555_0002);
        check("x5_b", rd_b[0], 32'h5555_0002);

        // 3: x0 stays zero, no bypass
        rd_addr[0] = 5'd0;
        we         = 2'b01;
        wr_addr[0] = 5'd0;
        wr_data[0] = 32'hDEAD_BEEF;
        #1;
        check("x0_byp_a", rd_a[0], 32'd0);
        step();
        idle_wr();
        #1;
        check("x0_a", rd_a[0], 32'd0);
        check("x0_b", rd_b[0], 32'd0);

        // 4: bypass on read port 1
        rd_addr[1] = 5'd7;
        we         = 2'b01;
        wr_addr[0] = 5'd7;
        wr_data[0] = 32'h1234_5678;
        #1;
        check("x7_byp_a", rd_a[1], 32'h1234_5678);
        check("x7_old_b", rd_b[1], 32'd0);
        step();
        idle_wr();
        #1;
        check("x7_a", rd_a[1], 32'h1234_5678);
        check("x7_b", rd_b[1], 32'h1234_5678);

        // 6: out-of-range address on the 24-entry file
        rd_addr[0] = 5'd30;
        rd_addr[1] = 5'd23;
        we         = 2'b11;
        wr_addr[0] = 5'd30;
        wr_addr[1] = 5'd23;
        wr_data[0] = 32'h0000_3030;
        wr_data[1] = 32'h0000_2323;
        #1;
        check("x30_byp_a", rd_a[0], 32'h0000_3030);
        check("x30_byp_b", rd_b[0], 32'd0);
        step();
        idle_wr();
        #1;
        check("x30_a", rd_a[0], 32'h0000_3030);
        check("x30_b", rd_b[0], 32'd0);
        check("x23_b", rd_b[1], 32'h0000_2323);

        // 5: reset during sweep restarts it and loses data
        rd_addr[0] = 5'd3;
        rd_addr[1] = 5'd5;
        we         = 2'b01;
        wr_addr[0] = 5'd3;
        wr_data[0] = 32'h0000_00FF;
        step();
        idle_wr();
        #1;
        check("x3_a", rd_a[0], 32'h0000_00FF);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        repeat (10) step();
        check("mid_busy_a", {31'd0, busy_a}, 32'd1);
        rst_ni = 1'b0;
        step();
        check("rerst_busy_b", {31'd0, busy_b}, 32'd1);
        rst_ni = 1'b1;
        count_sweep(0, da, db);
        check("resweep_a", 32'(da), 32'd32);
        check("resweep_b", 32'(db), 32'd24);
        #1;
        check("x3_lost_a", rd_a[0], 32'd0);
        check("x3_lost_b", rd_b[0], 32'd0);
        check("x5_lost_a", rd_a[1], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
